// File: rtl/vga_mem_arbiter.sv
// Arbiter sharing the single-port frame memory between the Nios II data master (m0) and the VGA fetcher (m1).
// Optional starvation guard for m0 is enabled by defining VGA_MEM_ARB_STARVE_GUARD_EN; otherwise m1 has strict priority.
module vga_mem_arbiter #(
  parameter int MEM_WORDS   = 62500,
  parameter int VGA_MAX_RUN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,
  output logic        m0_readdatavalid,
  input  logic [15:0] m1_address,
  input  logic        m1_read,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,
  output logic        m1_readdatavalid,
  output logic [15:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata
);

  if (VGA_MAX_RUN < 1 || VGA_MAX_RUN > 255) begin : g_bad_max_run
    $error("VGA_MAX_RUN must be in 1..255");
  end

  logic        req0;
  logic        req1;
  logic        gnt0;
  logic        gnt1;
  logic        starve;
  logic        in_range;
  logic        rd_accept;
  logic [15:0] sel_address;
  logic        tag_valid;
  logic        tag_owner;
  logic        tag_oor;
  logic [31:0] ret_data;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read;

`ifdef VGA_MEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] MAX_RUN = 8'(VGA_MAX_RUN);

  logic [7:0] run_cnt;

  assign starve = (run_cnt == MAX_RUN);

  // Counts consecutive m1 wins while m0 is kept waiting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt <= '0;
    end else if (gnt0 || !req0) begin
      run_cnt <= '0;
    end else if (gnt1 && run_cnt != MAX_RUN) begin
      run_cnt <= run_cnt + 8'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // No grants while reset is held so nothing reaches the memory
  always_comb begin
    gnt1 = reset_n & req1 & ~(req0 & starve);
    gnt0 = reset_n & req0 & ~gnt1;
  end

  assign sel_address = gnt0 ? m0_address : m1_address;
  assign in_range    = (32'(sel_address) < 32'(MEM_WORDS));

  // A simultaneous read+write from m0 is treated as a write only
  assign rd_accept = gnt1 | (gnt0 & ~m0_write);

  assign m0_waitrequest = ~reset_n | (req0 & ~gnt0);
  assign m1_waitrequest = ~reset_n | (req1 & ~gnt1);

  assign mem_address    = sel_address;
  assign mem_byteenable = gnt0 ? m0_byteenable : 4'hF;
  assign mem_writedata  = gnt0 ? m0_writedata : 32'h0;
  assign mem_chipselect = (gnt0 | gnt1) & in_range;
  assign mem_write      = gnt0 & m0_write & in_range;
  assign mem_clken      = 1'b1;

  // Return tag follows the memory's one-cycle read latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= 1'b0;
      tag_owner <= 1'b0;
      tag_oor   <= 1'b0;
    end else begin
      tag_valid <= rd_accept;
      tag_owner <= gnt1;
      tag_oor   <= ~in_range;
    end
  end

  assign ret_data = (tag_valid & ~tag_oor) ? mem_readdata : 32'h0;

  assign m0_readdatavalid = tag_valid & ~tag_owner;
  assign m1_readdatavalid = tag_valid & tag_owner;
  assign m0_readdata      = m0_readdatavalid ? ret_data : 32'h0;
  assign m1_readdata      = m1_readdatavalid ? ret_data : 32'h0;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter with a behavioural synchronous frame memory.
// Expectations for the starvation case follow VGA_MEM_ARB_STARVE_GUARD_EN.
module tb_vga_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [15:0] m0_address;
  logic [3:0]  m0_byteenable;
  logic        m0_read;
  logic        m0_write;
  logic [31:0] m0_writedata;
  logic [31:0] m0_readdata;
  logic        m0_waitrequest;
  logic        m0_readdatavalid;
  logic [15:0] m1_address;
  logic        m1_read;
  logic [31:0] m1_readdata;
  logic        m1_waitrequest;
  logic        m1_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_model [0:65535];

  typedef struct {
    logic        m0_read;
    logic        m0_write;
    logic [15:0] m0_address;
    logic        m1_read;
    logic [15:0] m1_address;
    logic        exp_wait0;
    logic        exp_wait1;
    logic        exp_cs;
    logic        exp_we;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs [9];

  vga_mem_arbiter #(.MEM_WORDS(62500), .VGA_MAX_RUN(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_readdata      (m0_readdata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_readdata      (m1_readdata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unselected cycles return a garbage pattern so out-of-range masking is observable
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byteenable[b]) mem_model[mem_address][b*8 +: 8] = mem_writedata[b*8 +: 8];
      end
      mem_readdata <= 32'hA5A5_5A5A;
    end else if (mem_chipselect) begin
      mem_readdata <= mem_model[mem_address];
    end else begin
      mem_readdata <= 32'hA5A5_5A5A;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic r0, input logic w0, input logic [15:0] a0,
                                input logic [3:0] be0, input logic [31:0] wd0,
                                input logic r1, input logic [15:0] a1);
    @(negedge clk);
    m0_read       = r0;
    m0_write      = w0;
    m0_address    = a0;
    m0_byteenable = be0;
    m0_writedata  = wd0;
    m1_read       = r1;
    m1_address    = a1;
    #1;
  endtask

  task automatic go_idle();
    apply_stimulus(1'b0, 1'b0, 16'h0000, 4'hF, 32'h0, 1'b0, 16'h0000);
  endtask

  initial begin
    int accept_cycle;
    int limit;

    for (int i = 0; i < 65536; i++) mem_model[i] = 32'hFFFF_FFFF;
    mem_model[16] = 32'hDEAD_BEEF;
    mem_readdata = 32'h0;

    vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0123};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100};
    vecs[2] = '{1'b1, 1'b0, 16'h0200, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0300};
    vecs[3] = '{1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040};
    vecs[4] = '{1'b1, 1'b1, 16'h0041, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0041};
    vecs[5] = '{1'b0, 1'b1, 16'hF424, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF424};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hF423, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF423};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF};
    vecs[8] = '{1'b0, 1'b1, 16'h0050, 1'b1, 16'h0060, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0060};

    // Reset with both masters requesting
    reset_n       = 1'b0;
    m0_read       = 1'b1;
    m0_write      = 1'b0;
    m0_address    = 16'h0010;
    m0_byteenable = 4'hF;
    m0_writedata  = 32'h0;
    m1_read       = 1'b1;
    m1_address    = 16'h0010;
    #1;
    check_output("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    check_output("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    check_output("rst_cs", 32'(mem_chipselect), 32'd0);
    check_output("rst_we", 32'(mem_write), 32'd0);
    check_output("rst_m0_valid", 32'(m0_readdatavalid), 32'd0);
    check_output("rst_m1_valid", 32'(m1_readdatavalid), 32'd0);
    check_output("rst_m0_data", m0_readdata, 32'h0);
    check_output("rst_m1_data", m1_readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    m0_read  = 1'b0;
    m1_read  = 1'b0;

    $display("[TB] single m0 read");
    apply_stimulus(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0, 1'b0, 16'h0000);
    check_output("rd0_wait", 32'(m0_waitrequest), 32'd0);
    check_output("rd0_cs", 32'(mem_chipselect), 32'd1);
    check_output("rd0_addr", 32'(mem_address), 32'h0010);
    go_idle();
    check_output("rd0_valid", 32'(m0_readdatavalid), 32'd1);
    check_output("rd0_data", m0_readdata, 32'hDEAD_BEEF);
    check_output("rd0_m1_valid", 32'(m1_readdatavalid), 32'd0);
    go_idle();
    check_output("rd0_valid_once", 32'(m0_readdatavalid), 32'd0);

    $display("[TB] partial write then read back");
    apply_stimulus(1'b0, 1'b1, 16'h0005, 4'b0011, 32'h1234_5678, 1'b0, 16'h0000);
    check_output("wr_wait", 32'(m0_waitrequest), 32'd0);
    check_output("wr_we", 32'(mem_write), 32'd1);
    check_output("wr_be", 32'(mem_byteenable), 32'h3);
    apply_stimulus(1'b1, 1'b0, 16'h0005, 4'hF, 32'h0, 1'b0, 16'h0000);
    check_output("wr_no_valid", 32'(m0_readdatavalid), 32'd0);
    go_idle();
    check_output("wr_rb_valid", 32'(m0_readdatavalid), 32'd1);
    check_output("wr_rb_data", m0_readdata, 32'hFFFF_5678);

    $display("[TB] grant table");
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].m0_read, vecs[i].m0_write, vecs[i].m0_address, 4'hF, 32'h1111_1111,
                     vecs[i].m1_read, vecs[i].m1_address);
      check_output($sformatf("vec%0d_wait0", i), 32'(m0_waitrequest), 32'(vecs[i].exp_wait0));
      check_output($sformatf("vec%0d_wait1", i), 32'(m1_waitrequest), 32'(vecs[i].exp_wait1));
      check_output($sformatf("vec%0d_cs", i), 32'(mem_chipselect), 32'(vecs[i].exp_cs));
      check_output($sformatf("vec%0d_we", i), 32'(mem_write), 32'(vecs[i].exp_we));
      check_output($sformatf("vec%0d_addr", i), 32'(mem_address), 32'(vecs[i].exp_addr));
    end
    go_idle();

    $display("[TB] out-of-range reads");
    apply_stimulus(1'b0, 1'b0, 16'h0000, 4'hF, 32'h0, 1'b1, 16'hF424);
    check_output("oor1_wait", 32'(m1_waitrequest), 32'd0);
    check_output("oor1_cs", 32'(mem_chipselect), 32'd0);
    apply_stimulus(1'b1, 1'b0, 16'hF424, 4'hF, 32'h0, 1'b0, 16'h0000);
    check_output("oor1_valid", 32'(m1_readdatavalid), 32'd1);
    check_output("oor1_data", m1_readdata, 32'h0);
    check_output("oor0_wait", 32'(m0_waitrequest), 32'd0);
    go_idle();
    check_output("oor0_valid", 32'(m0_readdatavalid), 32'd1);
    check_output("oor0_data", m0_readdata, 32'h0);

    $display("[TB] back-to-back reads from both masters");
    apply_stimulus(1'b0, 1'b0, 16'h0000, 4'hF, 32'h0, 1'b1, 16'h0010);
    apply_stimulus(1'b1, 1'b0, 16'h0005, 4'hF, 32'h0, 1'b0, 16'h0000);
    check_output("b2b_m1_valid", 32'(m1_readdatavalid), 32'd1);
    check_output("b2b_m1_data", m1_readdata, 32'hDEAD_BEEF);
    check_output("b2b_m0_valid0", 32'(m0_readdatavalid), 32'd0);
    go_idle();
    check_output("b2b_m0_valid", 32'(m0_readdatavalid), 32'd1);
    check_output("b2b_m0_data", m0_readdata, 32'hFFFF_5678);
    check_output("b2b_m1_valid0", 32'(m1_readdatavalid), 32'd0);

    $display("[TB] continuous VGA traffic with m0 pending");
    accept_cycle = 0;
`ifdef VGA_MEM_ARB_STARVE_GUARD_EN
    limit = 10;
`else
    limit = 100;
`endif
    for (int k = 1; k <= limit; k++) begin
      apply_stimulus(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0, 1'b1, 16'h0020);
      if (!m0_waitrequest) begin
        accept_cycle = k;
        break;
      end
    end
`ifdef VGA_MEM_ARB_STARVE_GUARD_EN
    check_output("starve_accept_cycle", 32'(accept_cycle), 32'd5);
    check_output("starve_m1_held", 32'(m1_waitrequest), 32'd1);
    apply_stimulus(1'b0, 1'b0, 16'h0000, 4'hF, 32'h0, 1'b1, 16'h0020);
    check_output("starve_m1_resumes", 32'(m1_waitrequest), 32'd0);
    check_output("starve_m0_valid", 32'(m0_readdatavalid), 32'd1);
    check_output("starve_m0_data", m0_readdata, 32'hDEAD_BEEF);
`else
    check_output("strict_no_accept", 32'(accept_cycle), 32'd0);
    apply_stimulus(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0, 1'b0, 16'h0000);
    check_output("strict_m0_after", 32'(m0_waitrequest), 32'd0);
    go_idle();
    check_output("strict_m0_valid", 32'(m0_readdatavalid), 32'd1);
    check_output("strict_m0_data", m0_readdata, 32'hDEAD_BEEF);
`endif
    go_idle();
    go_idle();

    $display("[TB] simultaneous write/read, then reset during a read");
    apply_stimulus(1'b0, 1'b1, 16'h0006, 4'hF, 32'hCAFE_F00D, 1'b1, 16'h0010);
    check_output("sim_m1_wait", 32'(m1_waitrequest), 32'd0);
    check_output("sim_m0_wait", 32'(m0_waitrequest), 32'd1);
    check_output("sim_we", 32'(mem_write), 32'd0);
    apply_stimulus(1'b0, 1'b1, 16'h0006, 4'hF, 32'hCAFE_F00D, 1'b0, 16'h0000);
    check_output("sim_m0_wait2", 32'(m0_waitrequest), 32'd0);
    check_output("sim_we2", 32'(mem_write), 32'd1);
    check_output("sim_m1_valid", 32'(m1_readdatavalid), 32'd1);
    check_output("sim_m1_data", m1_readdata, 32'hDEAD_BEEF);
    apply_stimulus(1'b0, 1'b0, 16'h0000, 4'hF, 32'h0, 1'b1, 16'h0010);
    check_output("mid_rd_accept", 32'(m1_waitrequest), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    m0_read = 1'b1;
    m1_read = 1'b1;
    #1;
    check_output("mid_rst_m1_valid", 32'(m1_readdatavalid), 32'd0);
    check_output("mid_rst_m1_data", m1_readdata, 32'h0);
    check_output("mid_rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    check_output("mid_rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    check_output("mid_rst_cs", 32'(mem_chipselect), 32'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    m0_read    = 1'b1;
    m0_address = 16'h0006;
    m1_read    = 1'b0;
    #1;
    check_output("post_rst_m0_wait", 32'(m0_waitrequest), 32'd0);
    check_output("post_rst_m1_valid", 32'(m1_readdatavalid), 32'd0);
    check_output("post_rst_m0_valid", 32'(m0_readdatavalid), 32'd0);
    go_idle();
    check_output("post_rst_rd_valid", 32'(m0_readdatavalid), 32'd1);
    check_output("post_rst_rd_data", m0_readdata, 32'hCAFE_F00D);
    check_output("post_rst_no_stale", 32'(m1_readdatavalid), 32'd0);
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
